ddr_phase_cal: RTL
==================

Name: ddr_phase_cal

Overview:
Read-phase calibration controller that drives the dynamic phase/delay inputs of the DDR clocking block. It waits for PLL lock, then sweeps all 16 phase steps (22.5° each). At each step it requests a test read from the PHY and records pass/fail. It then programs psda to the centre of the widest circular passing window. Runs on the management clock, alongside DDR init logic.

Parameters:
LOCK_WAIT, 256, cycles locked must stay high (synchronised) before sweeping
SETTLE, 32, cycles to wait after each psda change before probing
TIMEOUT, 1024, cycles to wait for sample_valid before recording a fail
MIN_WIN, 3, minimum passing-window length (steps) for success
FDLY_INIT, 4'b1111, constant fdly value driven throughout

Ports:
clk  in  1  management clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begins or restarts calibration
locked  in  1  PLL lock; asynchronous, 2-flop synchronised internally
sample_valid  in  1  one-cycle pulse, probe result available
sample_ok  in  1  probe result, qualified by sample_valid
psda  out  4  dynamic phase select to clocking block
fdly  out  4  dynamic CLKOUTP delay to clocking block
probe_req  out  1  one-cycle pulse, PHY performs a test read
pass_map  out  16  bit i = result at phase i
best_phase  out  4  selected phase
cal_busy  out  1  high from accepted start until DONE/FAIL
cal_done  out  1  level, calibration succeeded
cal_fail  out  1  level, calibration failed

Behaviour:
- Reset values: psda=0, fdly=FDLY_INIT, probe_req=0, pass_map=0, best_phase=0, cal_busy=0, cal_done=0, cal_fail=0. The FSM resets to IDLE.
- States: IDLE, WAIT_LOCK, SET_PHASE, SETTLE, PROBE, WAIT_RES, SCAN, DONE, FAIL.
- IDLE/DONE/FAIL: on start, clear pass_map, phase index=0, cal_done=cal_fail=0, cal_busy=1, then go to WAIT_LOCK. start is ignored in every other state.
- WAIT_LOCK: counts consecutive cycles with synchronised locked=1. The count resets whenever locked=0. Reaching LOCK_WAIT moves to SET_PHASE.
- SET_PHASE: psda<=index, then go to SETTLE. SETTLE waits SETTLE cycles.
- PROBE: probe_req=1 for exactly one cycle, then go to WAIT_RES.
- WAIT_RES:
  - sample_valid: pass_map[index]<=sample_ok.
  - No sample_valid within TIMEOUT cycles: pass_map[index]<=0.
  - If index==15, go to SCAN. Otherwise index++ and go to SET_PHASE.
- sample_valid outside WAIT_RES is ignored.
- Loss of lock in any state from SET_PHASE through WAIT_RES: abort, clear pass_map, psda<=0, return to WAIT_LOCK.
- SCAN: sequential 32-cycle walk over pass_map doubled (i=0..31, bit pass_map[i mod 16]).
  - run_len is capped at 16.
  - When run_len > best_len (strictly greater), record best_len=run_len and best_start=(i-run_len+1) mod 16. On ties, the first found wins.
  - centre=(best_start + best_len/2) mod 16, 4-bit wrap.
  - All-pass case: best_len=16, best_start=0, centre=8.
- After SCAN:
  - best_len>=MIN_WIN: best_phase<=centre, psda<=centre, go to DONE (cal_done=1).
  - Otherwise: best_phase<=0, psda<=0, go to FAIL (cal_fail=1).
  - cal_busy clears on entry to DONE or FAIL.
- fdly is constant FDLY_INIT unless the optional feature is enabled.
- Asynchronous reset mid-sweep returns everything to the reset values immediately.

Optional Feature:
DDR_PHASE_CAL_RELOCK_EN:
- Defined: in DONE, if synchronised locked falls, clear cal_done, set cal_busy, and re-enter WAIT_LOCK for a full recalibration without needing start.
- Undefined: DONE ignores locked. cal_done holds until the next start.

Decomposition:
- Shared package/defines:
  - FSM state encodings.
  - PHASE_STEPS=16.
  - Phase width 4.
  - Default FDLY_INIT constant, shared with the clocking wrapper's delay table.
- One natural sub-module, ddr_phase_window: the sequential circular longest-run finder.
  - Inputs: start pulse and 16-bit map.
  - Outputs: best_start, best_len, centre, done pulse.

Test Plan:
- locked=1 from reset; phases 5..9 pass, rest fail -> pass_map=16'h03E0, best_phase=7, psda=7, cal_done=1.
- Wrapping window: phases 14,15,0,1,2 pass -> best_len=5, best_start=14, best_phase=0, cal_done=1.
- Only phases 3,4 pass (MIN_WIN=3) -> cal_fail=1, psda=0, best_phase=0, pass_map=16'h0018.
- No sample_valid at phase 6 -> after TIMEOUT, pass_map[6]=0 and the sweep continues; probe_req count totals 16.
- locked dropped for 1 cycle during phase 9 SETTLE -> pass_map cleared, WAIT_LOCK restarts, a full 16-step sweep follows, and the final result matches the undisturbed run.
- All phases pass -> best_phase=8. With DDR_PHASE_CAL_RELOCK_EN, dropping locked in DONE -> cal_done=0 and cal_busy=1 with no start pulse.

Source files
------------

// File: rtl/ddr_phase_cal_pkg.sv
// ============================================================================
//  Module      : ddr_phase_cal_pkg
//  Description : Shared types and constants for the DDR read-phase
//                calibration controller and its window finder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_phase_cal_pkg;

    localparam int PHASE_STEPS = 16;
    localparam int PHASE_W     = 4;

    // Default CLKOUTP delay; the clocking wrapper's delay table uses the same value.
    localparam logic [3:0] FDLY_INIT_DEFAULT = 4'b1111;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_LOCK = 4'd1,
        ST_SET_PHASE = 4'd2,
        ST_SETTLE    = 4'd3,
        ST_PROBE     = 4'd4,
        ST_WAIT_RES  = 4'd5,
        ST_SCAN      = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAIL      = 4'd8
    } cal_state_e;

endpackage

`default_nettype wire

// File: rtl/ddr_phase_cal_window.sv
// ============================================================================
//  Module      : ddr_phase_window
//  Description : Sequential circular longest-run finder. Walks the 16-bit
//                pass map twice (32 cycles) so runs that wrap past phase 15
//                are seen whole. Ties keep the first run found.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_phase_window
    import ddr_phase_cal_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PHASE_STEPS-1:0] map,
    output logic [PHASE_W-1:0]     best_start,
    output logic [PHASE_W:0]       best_len,
    output logic                   done
);

    logic [4:0]         i_q, i_d;
    logic               busy_q, busy_d;
    logic [PHASE_W:0]   run_q, run_d;
    logic [PHASE_W:0]   blen_q, blen_d;
    logic [PHASE_W-1:0] bstart_q, bstart_d;
    logic               done_q, done_d;

    logic               w_bit;
    logic [PHASE_W:0]   w_run_inc;

    // Walk step: extend or break the current run and keep the strictly longest.
    always_comb begin
        i_d       = i_q;
        busy_d    = busy_q;
        run_d     = run_q;
        blen_d    = blen_q;
        bstart_d  = bstart_q;
        done_d    = 1'b0;
        w_bit     = map[i_q[3:0]];
        // A run can never be longer than the ring itself.
        w_run_inc = (run_q == 5'd16) ? 5'd16 : run_q + 5'd1;

        if (start) begin
            busy_d   = 1'b1;
            i_d      = 5'd0;
            run_d    = 5'd0;
            blen_d   = 5'd0;
            bstart_d = 4'd0;
        end else if (busy_q) begin
            if (w_bit) begin
                run_d = w_run_inc;
                if (w_run_inc > blen_q) begin
                    blen_d   = w_run_inc;
                    // Modulo-16 start of the run ending at i (a 16-long run wraps to i+1).
                    bstart_d = i_q[3:0] - w_run_inc[3:0] + 4'd1;
                end
            end else begin
                run_d = 5'd0;
            end
            i_d = i_q + 5'd1;
            if (i_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Walk state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= 5'd0;
            busy_q   <= 1'b0;
            run_q    <= 5'd0;
            blen_q   <= 5'd0;
            bstart_q <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            i_q      <= i_d;
            busy_q   <= busy_d;
            run_q    <= run_d;
            blen_q   <= blen_d;
            bstart_q <= bstart_d;
            done_q   <= done_d;
        end
    end

    assign best_start = bstart_q;
    assign best_len   = blen_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: rtl/ddr_phase_cal.sv
// ============================================================================
//  Module      : ddr_phase_cal
//  Description : DDR read-phase calibration controller. Waits for stable PLL
//                lock, sweeps all 16 psda steps with one test read each, then
//                programs psda to the centre of the widest circular pass window.
//                Optional macro DDR_PHASE_CAL_RELOCK_EN: loss of lock while in
//                DONE triggers an automatic full recalibration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_phase_cal
    import ddr_phase_cal_pkg::*;
#(
    parameter int         LOCK_WAIT = 256,
    parameter int         SETTLE    = 32,
    parameter int         TIMEOUT   = 1024,
    parameter int         MIN_WIN   = 3,
    parameter logic [3:0] FDLY_INIT = FDLY_INIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   locked,
    input  logic                   sample_valid,
    input  logic                   sample_ok,
    output logic [PHASE_W-1:0]     psda,
    output logic [3:0]             fdly,
    output logic                   probe_req,
    output logic [PHASE_STEPS-1:0] pass_map,
    output logic [PHASE_W-1:0]     best_phase,
    output logic                   cal_busy,
    output logic                   cal_done,
    output logic                   cal_fail
);

    cal_state_e             state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [PHASE_W-1:0]     idx_q, idx_d;
    logic [PHASE_W-1:0]     psda_q, psda_d;
    logic [PHASE_STEPS-1:0] map_q, map_d;
    logic [PHASE_W-1:0]     best_q, best_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fail_q, fail_d;
    logic                   probe_q, probe_d;
    logic                   locked_meta_q, locked_sync_q;

    logic                   w_win_start;
    logic [PHASE_W-1:0]     w_win_best_start;
    logic [PHASE_W:0]       w_win_best_len;
    logic                   w_win_done;
    logic [PHASE_W-1:0]     w_centre;
    logic                   w_in_sweep;

    ddr_phase_window u_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_win_start),
        .map        (map_q),
        .best_start (w_win_best_start),
        .best_len   (w_win_best_len),
        .done       (w_win_done)
    );

    // Centre of the winning window; 4-bit add wraps around the phase ring.
    assign w_centre   = w_win_best_start + w_win_best_len[4:1];
    assign w_in_sweep = (state_q == ST_SET_PHASE) || (state_q == ST_SETTLE) ||
                        (state_q == ST_PROBE)     || (state_q == ST_WAIT_RES);

    // Next-state and output decode for the calibration sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        psda_d      = psda_q;
        map_d       = map_q;
        best_d      = best_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        probe_d     = 1'b0;
        w_win_start = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    map_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_LOCK;
                end
`ifdef DDR_PHASE_CAL_RELOCK_EN
                else if ((state_q == ST_DONE) && !locked_sync_q) begin
                    map_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_LOCK;
                end
`endif
            end
            ST_WAIT_LOCK: begin
                if (!locked_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == 16'(LOCK_WAIT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SET_PHASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SET_PHASE: begin
                psda_d  = idx_q;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 16'(SETTLE - 1)) begin
                    probe_d = 1'b1;
                    state_d = ST_PROBE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_PROBE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                // A missing response is recorded as a fail for this phase.
                if (sample_valid || (cnt_q == 16'(TIMEOUT - 1))) begin
                    map_d[idx_q] = sample_valid & sample_ok;
                    if (idx_q == 4'(PHASE_STEPS - 1)) begin
                        w_win_start = 1'b1;
                        state_d     = ST_SCAN;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SET_PHASE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SCAN: begin
                if (w_win_done) begin
                    busy_d = 1'b0;
                    if ({27'd0, w_win_best_len} >= MIN_WIN) begin
                        best_d  = w_centre;
                        psda_d  = w_centre;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        best_d  = '0;
                        psda_d  = '0;
                        fail_d  = 1'b1;
                        state_d = ST_FAIL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lock loss during the sweep invalidates every result gathered so far.
        if (w_in_sweep && !locked_sync_q) begin
            map_d   = '0;
            psda_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
            probe_d = 1'b0;
            state_d = ST_WAIT_LOCK;
        end
    end

    // State and output registers, plus the two-flop lock synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            psda_q        <= '0;
            map_q         <= '0;
            best_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            probe_q       <= 1'b0;
            locked_meta_q <= 1'b0;
            locked_sync_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            psda_q        <= psda_d;
            map_q         <= map_d;
            best_q        <= best_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            probe_q       <= probe_d;
            locked_meta_q <= locked;
            locked_sync_q <= locked_meta_q;
        end
    end

    assign psda       = psda_q;
    assign fdly       = FDLY_INIT;
    assign probe_req  = probe_q;
    assign pass_map   = map_q;
    assign best_phase = best_q;
    assign cal_busy   = busy_q;
    assign cal_done   = done_q;
    assign cal_fail   = fail_q;

endmodule

`default_nettype wire
